// File: rtl/conv_seq_pkg.sv
// Shared types and default sizing for the convolution layer sequencer.
package conv_seq_pkg;

    localparam int unsigned LAYER_W_DFLT        = 4;
    localparam int unsigned CNT_W_DFLT          = 32;
    localparam int unsigned TIMEOUT_CYCLES_DFLT = 4096;

    typedef enum logic [1:0] {
        IDLE,
        ENABLE,
        RELEASE,
        FINISH
    } seq_state_e;

endpackage

// File: rtl/seq_watchdog.sv
// Cycle watchdog: counts while enabled, restarts on clear, and pulses
// expire on the LIMIT-th counted cycle.
module seq_watchdog
    import conv_seq_pkg::*;
#(
    parameter int unsigned LIMIT = TIMEOUT_CYCLES_DFLT
) (
    input  logic clk,
    input  logic rst,
    input  logic clear_i,
    input  logic count_en_i,
    output logic expire_o
);

    localparam int unsigned W = $clog2(LIMIT + 1);

    logic [W-1:0] cnt_q, cnt_d;

    assign expire_o = count_en_i && (cnt_q == W'(LIMIT - 1));

    // Next count: clear wins, otherwise advance while enabled (stops at the limit)
    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (count_en_i && !expire_o) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    // Count register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/conv_layer_sequencer.sv
// Runs a Conv2D engine over num_layers layers using an en/done handshake.
// Optional feature macro: SEQ_TIMEOUT_EN adds an ENABLE-state watchdog that
// aborts the run and raises a sticky error flag.
module conv_layer_sequencer
    import conv_seq_pkg::*;
#(
    parameter int unsigned LAYER_W        = LAYER_W_DFLT,
    parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DFLT,
    parameter int unsigned CNT_W          = CNT_W_DFLT
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [LAYER_W-1:0] num_layers,
    output logic               busy,
    output logic               en_conv2d,
    input  logic               done,
    output logic [LAYER_W-1:0] layer_idx,
    output logic               all_done,
    output logic               error,
    output logic [CNT_W-1:0]   busy_cycles
);

    if (TIMEOUT_CYCLES == 0) begin : g_bad_timeout
        $error("conv_layer_sequencer: TIMEOUT_CYCLES must be at least 1");
    end

    seq_state_e         state_q, state_d;
    logic [LAYER_W-1:0] layers_q, layers_d;
    logic [LAYER_W-1:0] idx_q, idx_d;
    logic [CNT_W-1:0]   cyc_q, cyc_d;
    logic               accept;

    // Outputs decode straight from the state register, so reset clears them at once
    assign en_conv2d   = (state_q == ENABLE);
    assign busy        = (state_q == ENABLE) || (state_q == RELEASE);
    assign all_done    = (state_q == FINISH);
    assign layer_idx   = idx_q;
    assign busy_cycles = cyc_q;

`ifdef SEQ_TIMEOUT_EN
    logic wd_expire;
    logic err_q, err_d;

    seq_watchdog #(
        .LIMIT(TIMEOUT_CYCLES)
    ) u_wd (
        .clk       (clk),
        .rst       (rst),
        .clear_i   (state_q != ENABLE),
        .count_en_i(state_q == ENABLE),
        .expire_o  (wd_expire)
    );

    assign error = err_q;

    // Sticky error: set on a watchdog abort (done has priority), cleared by a new run
    always_comb begin
        err_d = err_q;
        if (accept) begin
            err_d = 1'b0;
        end else if ((state_q == ENABLE) && !done && wd_expire) begin
            err_d = 1'b1;
        end
    end

    // Error flag register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end
`else
    assign error = 1'b0;
`endif

    // Next-state logic and start acceptance
    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    accept  = 1'b1;
                    state_d = (num_layers != '0) ? ENABLE : FINISH;
                end
            end
            ENABLE: begin
                if (done) begin
                    state_d = RELEASE;
                end
`ifdef SEQ_TIMEOUT_EN
                else if (wd_expire) begin
                    state_d = IDLE;
                end
`endif
            end
            RELEASE: begin
                if (!done) begin
                    state_d = (idx_q < layers_q - LAYER_W'(1)) ? ENABLE : FINISH;
                end
            end
            FINISH:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath next values: latch count on start, step index per layer, count busy cycles
    always_comb begin
        layers_d = layers_q;
        idx_d    = idx_q;
        cyc_d    = cyc_q;
        if (accept) begin
            layers_d = num_layers;
            idx_d    = '0;
            cyc_d    = '0;
        end else begin
            if (busy && (cyc_q != '1)) begin
                cyc_d = cyc_q + CNT_W'(1);
            end
            if ((state_q == RELEASE) && (state_d == ENABLE)) begin
                idx_d = idx_q + LAYER_W'(1);
            end
        end
    end

    // State and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            layers_q <= '0;
            idx_q    <= '0;
            cyc_q    <= '0;
        end else begin
            state_q  <= state_d;
            layers_q <= layers_d;
            idx_q    <= idx_d;
            cyc_q    <= cyc_d;
        end
    end

endmodule
